keypad_scanner: RTL

Matrix keypad reader for a 4x4 membrane keypad. It is the input-side counterpart of the multiplexed seven-segment driver. The block walks a one-hot active-low row strobe, samples the active-low column lines, debounces the press, and reports one ASCII character per debounced press. Its output byte uses the same ASCII-character convention the display path consumes, so a key code can be routed straight into a display digit slot.

---
 rtl/keypad_scanner.sv | 109 ++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce, emitting one ASCII code per press
module keypad_scanner #(
  parameter int DIVISOR  = 50000,
  parameter int DEBOUNCE = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_sense,
  output logic [3:0] row_drive,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int DW = $clog2(DIVISOR);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(DIVISOR - 1);
  localparam logic [CW-1:0] DB = CW'(DEBOUNCE);
  // byte {row,col} of this string is the key at that position; index 0 is the last character
  localparam logic [127:0] KEYMAP = "D#0*C987B654A321";
  typedef enum logic [1:0] {SCAN, DEB, HELD, REL} state_t;
  state_t        state_q;
  logic [3:0]    s1_q, col_s_q;
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    row_q, col_q, sel, acc_col;
  logic [7:0]    key_code_q;
  logic          key_valid_q, key_held_q;
  logic          tick, present, released, cap_low, accept, drop;
  always_comb begin
    tick     = div_q == DIV_MAX;
    div_d    = tick ? '0 : div_q + 1'b1;
    present  = ~&col_s_q;
    released = &col_s_q;
    sel      = ~col_s_q[0] ? 2'd0 : ~col_s_q[1] ? 2'd1 : ~col_s_q[2] ? 2'd2 : 2'd3;
    cnt_d    = (cnt_q == DB) ? cnt_q : cnt_q + 1'b1;
    cap_low  = ~col_s_q[col_q];
    acc_col  = (state_q == SCAN) ? sel : col_q;
    accept   = tick & (((state_q == SCAN) & present & (DEBOUNCE == 1)) |
                       ((state_q == DEB) & cap_low & (cnt_d == DB)));
    drop     = tick & released & (((state_q == HELD) & (DEBOUNCE == 1)) |
                                  ((state_q == REL) & (cnt_d == DB)));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SCAN;
      s1_q        <= 4'hF;
      col_s_q     <= 4'hF;
      div_q       <= '0;
      cnt_q       <= '0;
      row_q       <= 2'd0;
      col_q       <= 2'd0;
      key_code_q  <= 8'h00;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      s1_q        <= col_sense;
      col_s_q     <= s1_q;
      div_q       <= div_d;
      key_valid_q <= accept;
      if (accept) begin
        key_code_q <= KEYMAP[{row_q, acc_col, 3'b000} +: 8];
        key_held_q <= 1'b1;
      end else if (drop) begin
        key_held_q <= 1'b0;
      end
      if (tick) begin
        case (state_q)
          SCAN: if (present) begin
            col_q   <= sel;
            cnt_q   <= CW'(1);
            state_q <= (DEBOUNCE == 1) ? HELD : DEB;
          end else begin
            row_q <= row_q + 2'd1;
          end
          DEB: if (cap_low) begin
            cnt_q <= cnt_d;
            if (cnt_d == DB) state_q <= HELD;
          end else begin
            state_q <= SCAN;
            row_q   <= row_q + 2'd1;
          end
          HELD: if (released) begin
            cnt_q <= CW'(1);
            if (DEBOUNCE == 1) begin
              state_q <= SCAN;
              row_q   <= row_q + 2'd1;
            end else begin
              state_q <= REL;
            end
          end
          REL: if (!released) begin
            state_q <= HELD;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_d == DB) begin
              state_q <= SCAN;
              row_q   <= row_q + 2'd1;
            end
          end
          default: state_q <= SCAN;
        endcase
      end
    end
  end
  assign row_drive = ~(4'b0001 << row_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
endmodule
